// File: rtl/control_multiciclo.sv
// control_multiciclo: RV32I multi-cycle main control FSM (clk/nreset; opcode, funct3_0, cond_alu, listo_mem in; ALU modo, mux selects, write enables, memory requests, sticky error out)
module control_multiciclo #(
  parameter int unsigned ESPERA_MAX = 15
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [6:0] opcode,
  input  logic       funct3_0,
  input  logic       cond_alu,
  input  logic       listo_mem,
  output logic [1:0] modo_alu,
  output logic [1:0] sel_a,
  output logic [1:0] sel_b,
  output logic       sel_dir,
  output logic       sel_pc,
  output logic [1:0] sel_res,
  output logic       escribe_pc,
  output logic       escribe_ir,
  output logic       escribe_reg,
  output logic       lee_mem,
  output logic       escribe_mem,
  output logic [1:0] error
);
  typedef enum logic [3:0] {
    ARRANQUE, BUSQUEDA, DECODIFICA, EJEC_R, EJEC_I, LUI, DIRECCION, LECTURA,
    ESCRIBE_MEM, ESCRITURA, ESCRIBE_REG, SALTO, JAL, JALR, INVALIDA
  } estado_t;
  estado_t estado, sig;
  logic [7:0] cuenta;
  logic espera, vence;
  assign espera = estado inside {BUSQUEDA, LECTURA, ESCRITURA};
  assign vence  = espera && !listo_mem && cuenta == 8'(ESPERA_MAX);
  always_comb begin
    sig = estado;
    case (estado)
      ARRANQUE:   sig = BUSQUEDA;
      BUSQUEDA:   sig = listo_mem ? DECODIFICA : vence ? INVALIDA : BUSQUEDA;
      DECODIFICA:
        case (opcode)
          7'b0110011:             sig = EJEC_R;
          7'b0010011:             sig = EJEC_I;
          7'b0000011, 7'b0100011: sig = DIRECCION;
          7'b1100011:             sig = SALTO;
          7'b1101111:             sig = JAL;
          7'b1100111:             sig = JALR;
          7'b0110111:             sig = LUI;
          7'b0010111:             sig = ESCRIBE_REG;
          default:                sig = INVALIDA;
        endcase
      EJEC_R, EJEC_I, LUI: sig = ESCRIBE_REG;
      DIRECCION:  sig = opcode == 7'b0000011 ? LECTURA : ESCRITURA;
      LECTURA:    sig = listo_mem ? ESCRIBE_MEM : vence ? INVALIDA : LECTURA;
      ESCRITURA:  sig = listo_mem ? BUSQUEDA : vence ? INVALIDA : ESCRITURA;
      ESCRIBE_MEM, ESCRIBE_REG, SALTO, JAL, JALR: sig = BUSQUEDA;
      default:    sig = INVALIDA;
    endcase
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      estado <= ARRANQUE;
      cuenta <= '0;
      error  <= '0;
    end else begin
      estado <= sig;
      cuenta <= (espera && sig == estado) ? cuenta + 8'd1 : '0;
      error  <= vence ? 2'b10 : (estado == DECODIFICA && sig == INVALIDA) ? 2'b01 : error;
    end
  assign modo_alu    = estado == EJEC_R ? 2'b10 : estado == EJEC_I ? 2'b01 : estado == SALTO ? 2'b11 : 2'b00;
  assign sel_a       = estado inside {EJEC_R, EJEC_I, DIRECCION, SALTO, JALR} ? 2'b01 :
                       estado == DECODIFICA ? 2'b10 : estado == LUI ? 2'b11 : 2'b00;
  assign sel_b       = estado == BUSQUEDA ? 2'b10 :
                       estado inside {DECODIFICA, EJEC_I, LUI, DIRECCION, JALR} ? 2'b01 : 2'b00;
  assign sel_dir     = estado inside {LECTURA, ESCRITURA};
  assign sel_pc      = estado inside {SALTO, JAL};
  assign sel_res     = estado == ESCRIBE_MEM ? 2'b01 : estado inside {JAL, JALR} ? 2'b10 : 2'b00;
  assign escribe_ir  = estado == BUSQUEDA && listo_mem;
  assign escribe_pc  = escribe_ir || (estado == SALTO && (cond_alu ^ funct3_0)) || estado inside {JAL, JALR};
  assign escribe_reg = estado inside {ESCRIBE_MEM, ESCRIBE_REG, JAL, JALR};
  assign lee_mem     = estado inside {BUSQUEDA, LECTURA};
  assign escribe_mem = estado == ESCRITURA;
endmodule

// File: tb/tb_control_multiciclo.sv
// tb_control_multiciclo: table-driven and hand-sequenced checks of the multi-cycle control FSM
module tb_control_multiciclo;
  logic clk = 0, nreset = 0;
  logic [6:0] opcode = '0;
  logic funct3_0 = 0, cond_alu = 0, listo_mem = 0;
  logic [1:0] modo_alu, sel_a, sel_b, sel_res, error;
  logic sel_dir, sel_pc, escribe_pc, escribe_ir, escribe_reg, lee_mem, escribe_mem;
  int checks = 0, errors = 0;
  control_multiciclo #(.ESPERA_MAX(15)) dut (
    .clk(clk), .nreset(nreset), .opcode(opcode), .funct3_0(funct3_0), .cond_alu(cond_alu),
    .listo_mem(listo_mem), .modo_alu(modo_alu), .sel_a(sel_a), .sel_b(sel_b), .sel_dir(sel_dir),
    .sel_pc(sel_pc), .sel_res(sel_res), .escribe_pc(escribe_pc), .escribe_ir(escribe_ir),
    .escribe_reg(escribe_reg), .lee_mem(lee_mem), .escribe_mem(escribe_mem), .error(error)
  );
  always #5 clk = ~clk;
  logic [16:0] obs;
  assign obs = {modo_alu, sel_a, sel_b, sel_dir, sel_pc, sel_res, escribe_pc, escribe_ir,
                escribe_reg, lee_mem, escribe_mem, error};
  function automatic logic [16:0] e(input int m, a, b, d, p, r, epc, eir, erg, lee, em, er);
    return {2'(m), 2'(a), 2'(b), 1'(d), 1'(p), 2'(r), 1'(epc), 1'(eir), 1'(erg), 1'(lee), 1'(em), 2'(er)};
  endfunction
  typedef struct {
    logic [6:0]  op;
    logic        f3;
    logic        cond;
    logic        listo;
    logic [16:0] want;
  } vec_t;
  vec_t v[$];
  logic [16:0] zero, fetch, fwait, dec, wreg, dirc, salto_t, salto_n;
  task automatic chk(input string n, input logic [16:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got=%05h want=%05h", n, obs, want);
    end
  endtask
  task automatic step(input logic [6:0] op, input logic f, c, l, input logic [16:0] want, input string n);
    opcode = op; funct3_0 = f; cond_alu = c; listo_mem = l;
    @(negedge clk);
    chk(n, want);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    nreset = 0;
    listo_mem = 1;
    #1 chk("reset_zero", zero);
    @(posedge clk);
    #1 nreset = 1;
  endtask
  initial begin
    zero    = '0;
    fetch   = e(0, 0, 2, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    fwait   = e(0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    dec     = e(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wreg    = e(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    dirc    = e(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    salto_t = e(3, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    salto_n = e(3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    v.push_back('{7'b0110011, 1'b0, 1'b0, 1'b1, zero});
    v.push_back('{7'b0110011, 1'b0, 1'b0, 1'b1, fetch});
    v.push_back('{7'b0110011, 1'b0, 1'b0, 1'b1, dec});
    v.push_back('{7'b0110011, 1'b0, 1'b0, 1'b1, e(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    v.push_back('{7'b0110011, 1'b0, 1'b0, 1'b1, wreg});
    v.push_back('{7'b0010011, 1'b0, 1'b0, 1'b0, fwait});
    v.push_back('{7'b0010011, 1'b0, 1'b0, 1'b1, fetch});
    v.push_back('{7'b0010011, 1'b0, 1'b0, 1'b1, dec});
    v.push_back('{7'b0010011, 1'b0, 1'b0, 1'b1, e(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    v.push_back('{7'b0010011, 1'b0, 1'b0, 1'b1, wreg});
    v.push_back('{7'b0000011, 1'b0, 1'b0, 1'b1, fetch});
    v.push_back('{7'b0000011, 1'b0, 1'b0, 1'b1, dec});
    v.push_back('{7'b0000011, 1'b0, 1'b0, 1'b1, dirc});
    v.push_back('{7'b0000011, 1'b0, 1'b0, 1'b0, e(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0)});
    v.push_back('{7'b0000011, 1'b0, 1'b0, 1'b0, e(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0)});
    v.push_back('{7'b0000011, 1'b0, 1'b0, 1'b0, e(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0)});
    v.push_back('{7'b0000011, 1'b0, 1'b0, 1'b1, e(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0)});
    v.push_back('{7'b0000011, 1'b0, 1'b0, 1'b1, e(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0)});
    v.push_back('{7'b0100011, 1'b0, 1'b0, 1'b1, fetch});
    v.push_back('{7'b0100011, 1'b0, 1'b0, 1'b1, dec});
    v.push_back('{7'b0100011, 1'b0, 1'b0, 1'b1, dirc});
    v.push_back('{7'b0100011, 1'b0, 1'b0, 1'b0, e(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0)});
    v.push_back('{7'b0100011, 1'b0, 1'b0, 1'b1, e(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0)});
    v.push_back('{7'b1100011, 1'b0, 1'b1, 1'b1, fetch});
    v.push_back('{7'b1100011, 1'b0, 1'b1, 1'b1, dec});
    v.push_back('{7'b1100011, 1'b0, 1'b1, 1'b1, salto_t});
    v.push_back('{7'b1100011, 1'b1, 1'b1, 1'b1, fetch});
    v.push_back('{7'b1100011, 1'b1, 1'b1, 1'b1, dec});
    v.push_back('{7'b1100011, 1'b1, 1'b1, 1'b1, salto_n});
    v.push_back('{7'b1100011, 1'b1, 1'b0, 1'b1, fetch});
    v.push_back('{7'b1100011, 1'b1, 1'b0, 1'b1, dec});
    v.push_back('{7'b1100011, 1'b1, 1'b0, 1'b1, salto_t});
    v.push_back('{7'b1101111, 1'b0, 1'b0, 1'b1, fetch});
    v.push_back('{7'b1101111, 1'b0, 1'b0, 1'b1, dec});
    v.push_back('{7'b1101111, 1'b0, 1'b0, 1'b1, e(0, 0, 0, 0, 1, 2, 1, 0, 1, 0, 0, 0)});
    v.push_back('{7'b1100111, 1'b0, 1'b0, 1'b1, fetch});
    v.push_back('{7'b1100111, 1'b0, 1'b0, 1'b1, dec});
    v.push_back('{7'b1100111, 1'b0, 1'b0, 1'b1, e(0, 1, 1, 0, 0, 2, 1, 0, 1, 0, 0, 0)});
    v.push_back('{7'b0110111, 1'b0, 1'b0, 1'b1, fetch});
    v.push_back('{7'b0110111, 1'b0, 1'b0, 1'b1, dec});
    v.push_back('{7'b0110111, 1'b0, 1'b0, 1'b1, e(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    v.push_back('{7'b0110111, 1'b0, 1'b0, 1'b1, wreg});
    v.push_back('{7'b0010111, 1'b0, 1'b0, 1'b1, fetch});
    v.push_back('{7'b0010111, 1'b0, 1'b0, 1'b1, dec});
    v.push_back('{7'b0010111, 1'b0, 1'b0, 1'b1, wreg});
    v.push_back('{7'b0000000, 1'b0, 1'b0, 1'b1, fetch});
    v.push_back('{7'b0000000, 1'b0, 1'b0, 1'b1, dec});
    v.push_back('{7'b0000000, 1'b0, 1'b0, 1'b1, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
    do_reset();
    foreach (v[i]) step(v[i].op, v[i].f3, v[i].cond, v[i].listo, v[i].want, $sformatf("vec%0d", i));
    for (int i = 0; i < 20; i++)
      step(7'b0110011, 1'b0, 1'b1, 1'b1, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "invalid_hold");
    do_reset();
    step(7'b0110011, 1'b0, 1'b0, 1'b1, zero, "arranque");
    step(7'b0110011, 1'b0, 1'b0, 1'b1, fetch, "resume_fetch");
    do_reset();
    step(7'b0110011, 1'b0, 1'b0, 1'b0, zero, "arranque");
    for (int i = 0; i < 16; i++) step(7'b0110011, 1'b0, 1'b0, 1'b0, fwait, "timeout_wait");
    step(7'b0110011, 1'b0, 1'b0, 1'b1, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), "timeout_err");
    step(7'b0110011, 1'b0, 1'b0, 1'b1, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), "timeout_hold");
    do_reset();
    step(7'b0110011, 1'b0, 1'b0, 1'b0, zero, "arranque");
    for (int i = 0; i < 15; i++) step(7'b0110011, 1'b0, 1'b0, 1'b0, fwait, "edge_wait");
    step(7'b0110011, 1'b0, 1'b0, 1'b1, fetch, "edge_fetch");
    step(7'b0110011, 1'b0, 1'b0, 1'b1, dec, "edge_dec");
    do_reset();
    step(7'b0100011, 1'b0, 1'b0, 1'b1, zero, "arranque");
    step(7'b0100011, 1'b0, 1'b0, 1'b1, fetch, "st_fetch");
    step(7'b0100011, 1'b0, 1'b0, 1'b1, dec, "st_dec");
    step(7'b0100011, 1'b0, 1'b0, 1'b1, dirc, "st_dir");
    listo_mem = 0;
    @(negedge clk);
    chk("st_escritura", e(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    #1 nreset = 0;
    #1 chk("async_abort", zero);
    @(posedge clk);
    #1 nreset = 1;
    step(7'b0100011, 1'b0, 1'b0, 1'b1, zero, "abort_arranque");
    step(7'b0100011, 1'b0, 1'b0, 1'b1, fetch, "abort_fetch");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
